pss_sequence_generator: RTL

Generates the NR PSS frequency-domain sequence d_PSS(n), n=0..126, per 38.211 section 7.4.2.2, for a selectable N_ID_2. The 127 BPSK samples stream out on an AXI-stream master with backpressure, in the same I/Q packing the PSS correlator consumes. It is the transmit-side and test-side counterpart of the receive correlation chain, and feeds the tx resource-grid mapper and loopback benches.

---
 rtl/pss_sequence_generator.sv | 66 ++++++
 1 files changed

// File: rtl/pss_sequence_generator.sv
// pss_sequence_generator: streams the 127-sample NR PSS BPSK sequence for a selectable N_ID_2
module pss_sequence_generator #(
   parameter int OUT_DW  = 32,
   parameter int AMP     = 2**(OUT_DW/2-1)-1,
   parameter int PSS_LEN = 127
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [1:0]        N_id_2_i,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   input  logic              m_axis_out_tready,
   output logic              m_axis_out_tlast,
   output logic              busy_o,
   output logic              error_o
);
   localparam int H = OUT_DW/2;
   localparam logic [6:0] W_INIT = 7'b1110110;
   localparam logic [6:0] LAST = 7'(PSS_LEN-1);
   localparam logic [H-1:0] POS = H'(AMP);
   localparam logic [H-1:0] NEG = H'(-AMP);
   typedef enum logic [1:0] {IDLE, ADVANCE, RUN} state_t;
   state_t state;
   logic [6:0] w, cnt, step, adv_last;
   logic [1:0] nid;
   assign step = {w[4] ^ w[0], w[6:1]};
   assign adv_last = nid[1] ? 7'd85 : 7'd42;
   assign busy_o = state != IDLE;
   assign m_axis_out_tvalid = state == RUN;
   assign m_axis_out_tlast = m_axis_out_tvalid && cnt == LAST;
   assign m_axis_out_tdata = m_axis_out_tvalid ? {{H{1'b0}}, w[0] ? NEG : POS} : '0;
   // sequence control: start/error handling, pre-advance by 43*N_ID_2, then stream with backpressure
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         state   <= IDLE;
         w       <= W_INIT;
         cnt     <= '0;
         nid     <= '0;
         error_o <= 1'b0;
      end else begin
         error_o <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
               if (N_id_2_i == 2'd3) error_o <= 1'b1;
               else begin
                  nid   <= N_id_2_i;
                  w     <= W_INIT;
                  cnt   <= '0;
                  state <= N_id_2_i == 2'd0 ? RUN : ADVANCE;
               end
            end
            ADVANCE: begin
               w   <= step;
               cnt <= cnt == adv_last ? '0 : cnt + 7'd1;
               if (cnt == adv_last) state <= RUN;
            end
            RUN: if (m_axis_out_tready) begin
               w   <= step;
               cnt <= cnt == LAST ? '0 : cnt + 7'd1;
               if (cnt == LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
